// File: rtl/dmem_io_pkg.sv
// Shared constants for the data memory / IO controller: IO window offsets and FSM states.
package dmem_io_pkg;

    localparam logic [3:0] OFF_DISP0 = 4'h0;
    localparam logic [3:0] OFF_DISP1 = 4'h2;
    localparam logic [3:0] OFF_DISP2 = 4'h4;
    localparam logic [3:0] OFF_DISP3 = 4'h6;
    localparam logic [3:0] OFF_LED   = 4'h8;
    localparam logic [3:0] OFF_TIMER = 4'hC;
    localparam logic [3:0] OFF_SW    = 4'hE;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_io_ctrl_sw_debounce.sv
// One switch bit: two-flop synchroniser followed by a stability counter.
module sw_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_out
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            sw_out  <= 1'b0;
        end else begin
            sync_p0 <= sw_raw;
            sync_p1 <= sync_p0;
            // The edge that sees the DEBOUNCE_CYC-th consecutive difference commits the change.
            if (sync_p1 != sw_out) begin
                if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    sw_out <= sync_p1;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/dmem_io_ctrl.sv
// Handshaked data memory with memory-mapped displays, LEDs, timer and debounced switches.
// Optional byte stores are enabled by defining DMEM_BYTE_EN.
module dmem_io_ctrl
    import dmem_io_pkg::*;
#(
    parameter int                DATA_W       = 16,
    parameter int                ADDR_W       = 16,
    parameter int                DEPTH        = 128,
    parameter int                NUM_DISP     = 2,
    parameter int                NUM_SW       = 4,
    parameter int                DEBOUNCE_CYC = 4,
    parameter logic [ADDR_W-1:0] IO_BASE      = 'hfff0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  read,
    input  logic                  write,
    input  logic                  wsize,
    output logic                  ready,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  err,
    input  logic [NUM_SW-1:0]     io_sw,
    output logic [7*NUM_DISP-1:0] io_display,
    output logic [7:0]            io_led
);

    localparam int              WA        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W + 1)'(2 * DEPTH);

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [6:0]        disp [NUM_DISP];
    logic [7:0]        led;
    logic [DATA_W-1:0] timer;
    logic [NUM_SW-1:0] sw_db;
    logic [DATA_W-1:0] rdata_p1;
    logic              err_p1;
    logic              is_mem;
    logic              is_io;
    logic              rd_hit;
    logic              wr_hit;
    logic              accept;
    logic              do_wr;
    logic              do_rd;
    logic [3:0]        io_off;
    logic [WA-1:0]     widx;
    logic [DATA_W-1:0] rd_mux;

    assign is_mem = {1'b0, addr} < MEM_BYTES;
    assign is_io  = addr[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4];
    assign io_off = {addr[3:1], 1'b0};
    assign widx   = addr[WA:1];
    assign accept = (read | write) & ready;
    assign do_wr  = accept & write;
    assign do_rd  = accept & read & ~write;

    always_comb begin
        rd_mux = '0;
        rd_hit = 1'b0;
        wr_hit = 1'b0;
        if (is_mem) begin
            rd_mux = mem[widx];
            rd_hit = 1'b1;
            wr_hit = 1'b1;
        end else if (is_io) begin
            for (int i = 0; i < NUM_DISP; i++) begin
                if (io_off == OFF_DISP0 + 4'(2 * i)) begin
                    rd_mux = DATA_W'(disp[i]);
                    rd_hit = 1'b1;
                    wr_hit = 1'b1;
                end
            end
            if (io_off == OFF_LED) begin
                rd_mux = DATA_W'(led);
                rd_hit = 1'b1;
                wr_hit = 1'b1;
            end
            if (io_off == OFF_TIMER) begin
                rd_mux = timer;
                rd_hit = 1'b1;
            end
            if (io_off == OFF_SW) begin
                rd_mux = DATA_W'(sw_db);
                rd_hit = 1'b1;
            end
        end
    end

`ifdef DMEM_BYTE_EN
    // Big-endian lanes: even byte address is the high half of the word.
    always_ff @(posedge clock) begin
        if (do_wr && is_mem) begin
            if (wsize) begin
                if (addr[0]) mem[widx][7:0]  <= wdata[7:0];
                else         mem[widx][15:8] <= wdata[7:0];
            end else begin
                mem[widx] <= wdata;
            end
        end
    end
`else
    logic unused_wsize;
    assign unused_wsize = wsize;

    always_ff @(posedge clock) begin
        if (do_wr && is_mem) mem[widx] <= wdata;
    end
`endif

    // Accept stage -> response stage (_p1)
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_DISP; i++) disp[i] <= '0;
            led      <= '0;
            timer    <= '0;
            rdata_p1 <= '0;
            err_p1   <= 1'b0;
        end else begin
            timer  <= timer + DATA_W'(1);
            err_p1 <= accept & ((write & ~wr_hit) | (read & write) | (read & ~rd_hit));
            if (do_rd) rdata_p1 <= rd_mux;
            if (do_wr && is_io && wr_hit) begin
                for (int i = 0; i < NUM_DISP; i++) begin
                    if (io_off == OFF_DISP0 + 4'(2 * i)) disp[i] <= wdata[6:0];
                end
                if (io_off == OFF_LED) led <= wdata[7:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (do_rd) state_nx = RESP;
            RESP: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready  = (state == IDLE);
        rvalid = (state == RESP);
    end

    always_comb begin
        io_display = '0;
        for (int i = 0; i < NUM_DISP; i++) io_display[7*i +: 7] = disp[i];
    end

    assign rdata  = rdata_p1;
    assign err    = err_p1;
    assign io_led = led;

    for (genvar g = 0; g < NUM_SW; g++) begin : g_sw
        sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clock  (clock),
            .reset  (reset),
            .sw_raw (io_sw[g]),
            .sw_out (sw_db[g])
        );
    end

endmodule

// File: tb/tb_dmem_io_ctrl.sv
// Directed bench for dmem_io_ctrl with default parameters (DEPTH=128, NUM_DISP=2, DEBOUNCE_CYC=4).
module tb_dmem_io_ctrl;

    logic        clock;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        read;
    logic        write;
    logic        wsize;
    logic        ready;
    logic [15:0] rdata;
    logic        rvalid;
    logic        err;
    logic [3:0]  io_sw;
    logic [13:0] io_display;
    logic [7:0]  io_led;

    int n_chk  = 0;
    int n_fail = 0;
    int ecount = 0;

    dmem_io_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .addr       (addr),
        .wdata      (wdata),
        .read       (read),
        .write      (write),
        .wsize      (wsize),
        .ready      (ready),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .err        (err),
        .io_sw      (io_sw),
        .io_display (io_display),
        .io_led     (io_led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ecount equals the timer value just after each edge.
    task automatic tick();
        @(posedge clock);
        if (reset) ecount = 0;
        else       ecount++;
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr = a; wdata = d; write = 1'b1; read = 1'b0;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a);
        addr = a; read = 1'b1; write = 1'b0;
        tick();
        read = 1'b0;
    endtask

    initial begin
        reset = 1'b1; addr = '0; wdata = '0; read = 1'b0; write = 1'b0;
        wsize = 1'b0; io_sw = '0;
        ticks(2);
        reset = 1'b0;
        chk("rst_ready", ready, 1);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_disp", io_display, 0);
        chk("rst_led", io_led, 0);

        // Word write then immediate read-back
        wr(16'h0004, 16'h1234);
        chk("wr_mem_err", err, 0);
        rd(16'h0004);
        chk("rd_mem_rvalid", rvalid, 1);
        chk("rd_mem_rdata", rdata, 16'h1234);
        chk("rd_mem_ready", ready, 0);
        chk("rd_mem_err", err, 0);
        // Write offered while busy must be ignored
        addr = 16'h0004; wdata = 16'hDEAD; write = 1'b1;
        tick();
        write = 1'b0;
        chk("busy_err", err, 0);
        chk("busy_rvalid", rvalid, 0);
        chk("busy_ready", ready, 1);
        rd(16'h0004);
        chk("busy_nowrite", rdata, 16'h1234);
        tick();

        // Display, LED, unmapped IO write, timer
        wr(16'hFFF2, 16'h005B);
        chk("disp1_out", io_display[13:7], 7'h5B);
        chk("disp0_out", io_display[6:0], 7'h00);
        rd(16'hFFF2);
        chk("disp1_rd", rdata, 16'h005B);
        tick();
        wr(16'hFFF8, 16'h01A5);
        chk("led_out", io_led, 8'hA5);
        rd(16'hFFF8);
        chk("led_rd", rdata, 16'h00A5);
        tick();
        wr(16'hFFF6, 16'h0011);
        chk("disp3_unmapped_err", err, 1);
        chk("disp_unchanged", io_display, {7'h5B, 7'h00});
        rd(16'hFFFC);
        chk("timer_rd1", rdata, (ecount - 1) & 32'hFFFF);
        tick();
        wr(16'hFFFC, 16'h0000);
        chk("timer_wr_err", err, 1);
        tick();
        chk("err_pulse_clears", err, 0);
        rd(16'hFFFC);
        chk("timer_rd2", rdata, (ecount - 1) & 32'hFFFF);
        tick();

        // Debounce timing: rising edge lands on the 6th edge after the change
        io_sw = 4'b0001;
        ticks(5);
        rd(16'hFFFE);
        chk("sw_rise_early", rdata, 16'h0000);
        tick();
        rd(16'hFFFE);
        chk("sw_rise_set", rdata, 16'h0001);
        tick();
        io_sw = 4'b0000;
        ticks(6);
        rd(16'hFFFE);
        chk("sw_fall_done", rdata, 16'h0000);
        tick();
        io_sw = 4'b0010;
        tick();
        io_sw = 4'b0000;
        ticks(10);
        rd(16'hFFFE);
        chk("sw_glitch1", rdata, 16'h0000);
        tick();
        io_sw = 4'b0100;
        ticks(3);
        io_sw = 4'b0000;
        ticks(10);
        rd(16'hFFFE);
        chk("sw_glitch3", rdata, 16'h0000);
        tick();
        io_sw = 4'b1000;
        ticks(4);
        io_sw = 4'b0000;
        ticks(2);
        rd(16'hFFFE);
        chk("sw_pulse4", rdata, 16'h0008);
        ticks(12);

        // Unmapped read and simultaneous read&write
        rd(16'h0200);
        chk("unm_rvalid", rvalid, 1);
        chk("unm_rdata", rdata, 0);
        chk("unm_err", err, 1);
        tick();
        addr = 16'h0010; wdata = 16'h7777; read = 1'b1; write = 1'b1;
        tick();
        read = 1'b0; write = 1'b0;
        chk("rw_err", err, 1);
        chk("rw_rvalid", rvalid, 0);
        chk("rw_ready", ready, 1);
        rd(16'h0010);
        chk("rw_written", rdata, 16'h7777);
        chk("rw_rd_err", err, 0);
        tick();

        // Reset while a response is pending
        rd(16'h0004);
        chk("pre_rst_rvalid", rvalid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_ready", ready, 1);
        chk("midrst_disp", io_display, 0);
        chk("midrst_led", io_led, 0);
        chk("midrst_err", err, 0);
        rd(16'hFFFC);
        chk("midrst_timer", rdata, 16'h0000);
        tick();
        rd(16'h0004);
        chk("mem_kept", rdata, 16'h1234);
        tick();

        // Byte store
        wr(16'h0008, 16'hAABB);
        addr = 16'h0009; wdata = 16'h00CC; wsize = 1'b1; write = 1'b1;
        tick();
        write = 1'b0; wsize = 1'b0;
        rd(16'h0008);
`ifdef DMEM_BYTE_EN
        chk("byte_store", rdata, 16'hAACC);
`else
        chk("byte_store", rdata, 16'h00CC);
`endif
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
